// File: rtl/pipeline_pkg.sv
// Purpose: shared sequencer constants (state encoding, default drain length, register-index width).
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline_pkg;

    // Sequencer state encoding, kept as plain constants for legacy compatibility
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] HALTED = 3'd4;

    // Cycles the back half of the pipeline keeps clocking after HALT reaches EX
    localparam int DRAIN_CYCLES_DEFAULT = 3;

    // Register-file index width
    localparam int REG_W_DEFAULT = 5;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Purpose: load-use stall and taken-branch flush detection for the ID/EX boundary.
// Latency: purely combinational, same cycle.
// Backpressure: none; both outputs are forced low while the sequencer is not executing.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             active,
    input  logic             ex_memread,
    input  logic             ex_pcsel,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall,
    output logic             flush
);

    logic loadUse;

    // A load writing r0 never creates a dependency, since r0 is hard-wired to zero
    assign loadUse = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A taken branch flushes the younger instructions anyway, so it masks the stall
    assign flush = active && ex_pcsel;
    assign stall = active && loadUse && !ex_pcsel;

endmodule

// File: rtl/pipeline_sequencer.sv
// Purpose: run/step/halt sequencer for the 5-stage pipeline; generates stage enables and flushes.
// Latency: enables are combinational from registered state; step_done lags its step cycle by one.
// Backpressure: none; debug requests are sampled every cycle, load-use hazards stall IF/ID and PC.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 32,
    parameter int REG_W        = REG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             brk_req,
    input  logic             halt_instr,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_pcsel,
    output logic             stage_en,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]        stateQ;
    logic [2:0]        stateD;
    logic [DCNT_W-1:0] drainQ;
    logic [DCNT_W-1:0] drainD;
    logic [CNT_W-1:0]  cycleCnt;
    logic              stepDoneQ;
    logic              active;
    logic              draining;
    logic              stall;
    logic              branchFlush;

    assign active   = (stateQ == RUN) || (stateQ == STEP);
    assign draining = (stateQ == DRAIN);

    hazard_detect #(
        .REG_W (REG_W)
    ) uHazard (
        .active     (active),
        .ex_memread (ex_memread),
        .ex_pcsel   (ex_pcsel),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .stall      (stall),
        .flush      (branchFlush)
    );

    // Enables derive from registered state only, so an async reset drops them at once.
    // While draining, the front end is frozen and fed bubbles so nothing new enters.
    assign stage_en   = active || draining;
    assign pc_en      = active && !stall;
    assign ifid_en    = active && !stall;
    assign ifid_flush = draining || branchFlush;
    assign idex_flush = draining || branchFlush || stall;
    assign halted     = (stateQ == HALTED);
    assign step_done  = stepDoneQ;
    assign cycle_cnt  = cycleCnt;

    // Next-state and drain-counter logic; halt outranks break, run outranks step
    always_comb begin
        stateD = stateQ;
        drainD = drainQ;
        case (stateQ)
            IDLE: begin
                if (run_req) begin
                    stateD = RUN;
                end else if (step_req) begin
                    stateD = STEP;
                end
            end
            RUN: begin
                if (halt_instr) begin
                    stateD = DRAIN;
                    drainD = DRAIN_LOAD;
                end else if (brk_req) begin
                    stateD = IDLE;
                end
            end
            STEP: begin
                if (halt_instr) begin
                    stateD = DRAIN;
                    drainD = DRAIN_LOAD;
                end else begin
                    stateD = IDLE;
                end
            end
            DRAIN: begin
                if (drainQ == '0) begin
                    stateD = HALTED;
                end else begin
                    drainD = drainQ - 1'b1;
                end
            end
            HALTED: stateD = HALTED;
            default: stateD = IDLE;
        endcase
    end

    // State, drain counter and step completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            drainQ    <= '0;
            stepDoneQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            drainQ    <= drainD;
            stepDoneQ <= (stateQ == STEP) && !halt_instr;
        end
    end

    // Executed-cycle counter for debug readout; sticks at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCnt <= '0;
        end else if (stage_en && (cycleCnt != '1)) begin
            cycleCnt <= cycleCnt + CNT_W'(1);
        end
    end

endmodule
